wdt_multi: RTL



---
 rtl/wdt_pkg.sv | 10 +
 rtl/wdt_channel.sv | 56 +++++
 rtl/wdt_multi.sv | 26 ++
 3 files changed

// File: rtl/wdt_pkg.sv
// wdt_pkg: shared state encoding and parameter-legality check for the watchdog channels
`define WDT_LEGAL(w, t, wi) (((t) >= 1) && ((t) < (64'd1 << (w))) && ((wi) < (t)))
package wdt_pkg;
  typedef enum logic [1:0] {
    WDT_IDLE    = 2'd0,
    WDT_RUN     = 2'd1,
    WDT_EXPIRED = 2'd2,
    WDT_EARLY   = 2'd3
  } wdt_state_t;
endpackage

// File: rtl/wdt_channel.sv
// wdt_channel: one windowed watchdog FSM with its own timeout counter
module wdt_channel
  import wdt_pkg::*;
#(
  parameter int CNT_W   = 24,
  parameter int TIMEOUT = 150000,
  parameter int WINDOW  = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic kick,
  input  logic clear,
  output logic expired,
  output logic early
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WIN  = CNT_W'(WINDOW);
  if (!`WDT_LEGAL(CNT_W, TIMEOUT, WINDOW)) begin : g_bad
    $error("wdt_channel: illegal CNT_W/TIMEOUT/WINDOW");
  end
  wdt_state_t state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic in_window;
  if (WINDOW == 0) begin : g_nowin
    assign in_window = 1'b1;
  end else begin : g_win
    assign in_window = cnt >= WIN;
  end
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    if (clear) begin
      nxt_state = en ? WDT_RUN : WDT_IDLE;
      nxt_cnt   = '0;
    end else if (state == WDT_IDLE) begin
      nxt_state = en ? WDT_RUN : WDT_IDLE;
      nxt_cnt   = '0;
    end else if (state == WDT_RUN) begin
      nxt_state = !en ? WDT_IDLE : (kick && !in_window) ? WDT_EARLY :
                  (!kick && cnt == LAST) ? WDT_EXPIRED : WDT_RUN;
      nxt_cnt   = (!en || kick) ? '0 : (cnt == LAST) ? cnt : cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= WDT_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end
  assign expired = state == WDT_EXPIRED;
  assign early   = state == WDT_EARLY;
endmodule

// File: rtl/wdt_multi.sv
// wdt_multi: NUM_CH independent windowed watchdogs with an aggregated interrupt
module wdt_multi
  import wdt_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 24,
  parameter int TIMEOUT = 150000,
  parameter int WINDOW  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] kick,
  input  logic [NUM_CH-1:0] clear,
  output logic [NUM_CH-1:0] expired,
  output logic [NUM_CH-1:0] early,
  output logic              irq
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    wdt_channel #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .WINDOW(WINDOW)) u_ch (
      .clk(clk), .reset(reset), .en(en[i]), .kick(kick[i]), .clear(clear[i]),
      .expired(expired[i]), .early(early[i])
    );
  end
  assign irq = |{expired, early};
endmodule
